// File: rtl/param_register_file.sv
`default_nettype none
// ============================================================================
// Module   : param_register_file
// Purpose  : DEPTH x WIDTH register file, two combinational read ports, one
//            synchronous write port, optional hardwired-zero entry 0 and a
//            one-entry-per-cycle clear sweep after reset. Defining the macro
//            PARAM_REGISTER_FILE_BYPASS_EN enables write-to-read forwarding.
// Revision : 1.0
// ============================================================================
module param_register_file #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    read_register_1,
    input  logic [AW-1:0]    read_register_2,
    input  logic [AW-1:0]    write_register,
    input  logic [WIDTH-1:0] write_data,
    input  logic             reg_write,
    output logic [WIDTH-1:0] read_data_1,
    output logic [WIDTH-1:0] read_data_2,
    output logic             busy
);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam logic [AW-1:0] c_LAST_IDX = AW'(DEPTH - 1);
    localparam bit            c_ZERO_EN  = (ZERO_REG != 0);

    state_t           r_state;
    logic [AW-1:0]    r_clr_idx;
    logic             r_busy;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_wr_ok;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;

    assign w_wr_ok = reg_write && !(c_ZERO_EN && (write_register == '0));

    // Writes arriving during the sweep are dropped; upstream stalls on busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
            r_mem[0]  <= '0;
        end else if (r_state == S_CLEAR) begin
            r_mem[r_clr_idx] <= '0;
            r_clr_idx        <= r_clr_idx + 1'b1;
            if (r_clr_idx == c_LAST_IDX) begin
                r_state <= S_READY;
                r_busy  <= 1'b0;
            end
        end else if (w_wr_ok) begin
            r_mem[write_register] <= write_data;
        end
    end

    always_comb begin
        w_rd1 = r_mem[read_register_1];
`ifdef PARAM_REGISTER_FILE_BYPASS_EN
        if (reg_write && (write_register == read_register_1)) begin
            w_rd1 = write_data;
        end
`endif
        if (r_busy || (c_ZERO_EN && (read_register_1 == '0))) begin
            w_rd1 = '0;
        end
    end

    always_comb begin
        w_rd2 = r_mem[read_register_2];
`ifdef PARAM_REGISTER_FILE_BYPASS_EN
        if (reg_write && (write_register == read_register_2)) begin
            w_rd2 = write_data;
        end
`endif
        if (r_busy || (c_ZERO_EN && (read_register_2 == '0))) begin
            w_rd2 = '0;
        end
    end

    assign read_data_1 = w_rd1;
    assign read_data_2 = w_rd2;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_param_register_file.sv
`default_nettype none
// Testbench for param_register_file: default, ZERO_REG=0 and DEPTH=8/WIDTH=16
// instances checked against a queue of bench-computed expected values.
module tb_param_register_file;

`ifdef PARAM_REGISTER_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rr1, rr2, wr;
    logic [63:0] wd;
    logic        we;
    logic [63:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_busy, b_busy;
    logic [2:0]  s_rr1, s_rr2, s_wr;
    logic [15:0] s_wd;
    logic        s_we;
    logic [15:0] c_rd1, c_rd2;
    logic        c_busy;

    logic [63:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    param_register_file dut_a (
        .clk(clk), .reset(reset), .read_register_1(rr1), .read_register_2(rr2),
        .write_register(wr), .write_data(wd), .reg_write(we),
        .read_data_1(a_rd1), .read_data_2(a_rd2), .busy(a_busy)
    );

    param_register_file #(.ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .read_register_1(rr1), .read_register_2(rr2),
        .write_register(wr), .write_data(wd), .reg_write(we),
        .read_data_1(b_rd1), .read_data_2(b_rd2), .busy(b_busy)
    );

    param_register_file #(.WIDTH(16), .DEPTH(8)) dut_c (
        .clk(clk), .reset(reset), .read_register_1(s_rr1), .read_register_2(s_rr2),
        .write_register(s_wr), .write_data(s_wd), .reg_write(s_we),
        .read_data_1(c_rd1), .read_data_2(c_rd2), .busy(c_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        int n;
        n = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        while ((a_busy === 1'b1 || c_busy === 1'b1) && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (a_busy !== 1'b0) begin
            bad++;
            $display("FAIL sweep_timeout: busy=%b required 0", a_busy);
        end
    endtask

    task automatic test_reset();
        int n, cnt_a, cnt_c;
        logic [63:0] e;
        n = 0; cnt_a = 0; cnt_c = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd1);
        @(negedge clk);
        e = exp_q.pop_front(); total++;
        if ({63'd0, a_busy} !== e) begin bad++; $display("FAIL busy_after_reset: got %h required %h", a_busy, e); end
        e = exp_q.pop_front(); total++;
        if (a_rd1 !== e) begin bad++; $display("FAIL read_during_sweep: got %h required %h", a_rd1, e); end
        e = exp_q.pop_front(); total++;
        if ({63'd0, c_busy} !== e) begin bad++; $display("FAIL small_busy_after_reset: got %h required %h", c_busy, e); end
        while ((a_busy === 1'b1 || c_busy === 1'b1) && n < 200) begin
            tick();
            n++;
            if (a_busy !== 1'b1 && cnt_a == 0) cnt_a = n;
            if (c_busy !== 1'b1 && cnt_c == 0) cnt_c = n;
        end
        total++;
        if (cnt_a != 32) begin bad++; $display("FAIL sweep_len_32: got %0d required 32", cnt_a); end
        total++;
        if (cnt_c != 8) begin bad++; $display("FAIL sweep_len_8: got %0d required 8", cnt_c); end
        for (int i = 0; i < 32; i++) begin
            rr1 = 5'(i);
            rr2 = 5'(31 - i);
            exp_q.push_back(64'd0);
            exp_q.push_back(64'd0);
            #1;
            e = exp_q.pop_front(); total++;
            if (a_rd1 !== e) begin bad++; $display("FAIL cleared_p1 r%0d: got %h required %h", i, a_rd1, e); end
            e = exp_q.pop_front(); total++;
            if (a_rd2 !== e) begin bad++; $display("FAIL cleared_p2 r%0d: got %h required %h", 31 - i, a_rd2, e); end
        end
    endtask

    task automatic test_write_read();
        logic [63:0] e;
        wr = 5'd5; wd = 64'hDEAD_BEEF_0000_0001; we = 1'b1;
        tick();
        we = 1'b0;
        rr1 = 5'd5; rr2 = 5'd6;
        exp_q.push_back(64'hDEAD_BEEF_0000_0001);
        exp_q.push_back(64'd0);
        @(negedge clk);
        e = exp_q.pop_front(); total++;
        if (a_rd1 !== e) begin bad++; $display("FAIL write_read_r5: got %h required %h", a_rd1, e); end
        e = exp_q.pop_front(); total++;
        if (a_rd2 !== e) begin bad++; $display("FAIL write_read_r6: got %h required %h", a_rd2, e); end
    endtask

    task automatic test_zero_reg();
        logic [63:0] e;
        tick();
        rr1 = 5'd0; rr2 = 5'd0; wr = 5'd0; wd = '1; we = 1'b1;
        exp_q.push_back(64'd0);
        exp_q.push_back(BYP ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0);
        @(negedge clk);
        e = exp_q.pop_front(); total++;
        if (a_rd1 !== e) begin bad++; $display("FAIL zero_reg_inflight: got %h required %h", a_rd1, e); end
        e = exp_q.pop_front(); total++;
        if (b_rd1 !== e) begin bad++; $display("FAIL nozero_inflight: got %h required %h", b_rd1, e); end
        tick();
        we = 1'b0;
        exp_q.push_back(64'd0);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        #1;
        e = exp_q.pop_front(); total++;
        if (a_rd2 !== e) begin bad++; $display("FAIL zero_reg_r0: got %h required %h", a_rd2, e); end
        e = exp_q.pop_front(); total++;
        if (b_rd2 !== e) begin bad++; $display("FAIL nozero_r0: got %h required %h", b_rd2, e); end
    endtask

    task automatic test_chain();
        logic [63:0] e;
        logic [63:0] model [32];
        do_reset();
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        for (int i = 0; i < 31; i++) begin
            rr1 = 5'(i); rr2 = 5'(i + 1); wr = 5'(i + 1);
            wd = model[i] + 64'd1; we = 1'b1;
            exp_q.push_back(model[i]);
            exp_q.push_back(BYP ? model[i] + 64'd1 : model[i + 1]);
            @(negedge clk);
            e = exp_q.pop_front(); total++;
            if (a_rd1 !== e) begin bad++; $display("FAIL chain_read r%0d: got %h required %h", i, a_rd1, e); end
            e = exp_q.pop_front(); total++;
            if (a_rd2 !== e) begin bad++; $display("FAIL chain_fwd r%0d: got %h required %h", i + 1, a_rd2, e); end
            model[i + 1] = model[i] + 64'd1;
            tick();
        end
        we = 1'b0;
        rr1 = 5'd31;
        exp_q.push_back(model[31]);
        #1;
        e = exp_q.pop_front(); total++;
        if (a_rd1 !== e) begin bad++; $display("FAIL chain_r31: got %h required %h", a_rd1, e); end
    endtask

    task automatic test_reset_midsweep();
        int n;
        logic [63:0] e;
        n = 0;
        wr = 5'd7; wd = 64'h1234; we = 1'b1;
        tick();
        we = 1'b0;
        rr1 = 5'd7;
        exp_q.push_back(64'h1234);
        #1;
        e = exp_q.pop_front(); total++;
        if (a_rd1 !== e) begin bad++; $display("FAIL mid_r7_before: got %h required %h", a_rd1, e); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (9) tick();
        reset = 1'b1; wr = 5'd3; wd = 64'h5555; we = 1'b1;
        tick();
        reset = 1'b0;
        rr1 = 5'd3; rr2 = 5'd7;
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd1);
        @(negedge clk);
        e = exp_q.pop_front(); total++;
        if (a_rd1 !== e) begin bad++; $display("FAIL busy_read_r3: got %h required %h", a_rd1, e); end
        e = exp_q.pop_front(); total++;
        if (a_rd2 !== e) begin bad++; $display("FAIL busy_read_r7: got %h required %h", a_rd2, e); end
        e = exp_q.pop_front(); total++;
        if ({63'd0, a_busy} !== e) begin bad++; $display("FAIL busy_restart: got %h required %h", a_busy, e); end
        while (a_busy === 1'b1 && n < 200) begin
            tick();
            n++;
            if (n == 5) we = 1'b0;
        end
        we = 1'b0;
        total++;
        if (n != 32) begin bad++; $display("FAIL restart_len: got %0d required 32", n); end
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); total++;
        if (a_rd1 !== e) begin bad++; $display("FAIL lost_write_r3: got %h required %h", a_rd1, e); end
        e = exp_q.pop_front(); total++;
        if (a_rd2 !== e) begin bad++; $display("FAIL cleared_r7: got %h required %h", a_rd2, e); end
    endtask

    task automatic test_small();
        logic [63:0] e;
        s_wr = 3'd7; s_wd = 16'hABCD; s_we = 1'b1;
        tick();
        s_we = 1'b0;
        s_rr1 = 3'd7; s_rr2 = 3'd0;
        exp_q.push_back(64'hABCD);
        exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); total++;
        if ({48'd0, c_rd1} !== e) begin bad++; $display("FAIL small_r7: got %h required %h", c_rd1, e); end
        e = exp_q.pop_front(); total++;
        if ({48'd0, c_rd2} !== e) begin bad++; $display("FAIL small_r0: got %h required %h", c_rd2, e); end
        s_wr = 3'd0; s_wd = 16'hFFFF; s_we = 1'b1;
        tick();
        s_we = 1'b0;
        exp_q.push_back(64'hABCD);
        exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); total++;
        if ({48'd0, c_rd1} !== e) begin bad++; $display("FAIL small_r7_kept: got %h required %h", c_rd1, e); end
        e = exp_q.pop_front(); total++;
        if ({48'd0, c_rd2} !== e) begin bad++; $display("FAIL small_r0_zero: got %h required %h", c_rd2, e); end
    endtask

    initial begin
        reset = 1'b0; rr1 = '0; rr2 = '0; wr = '0; wd = '0; we = 1'b0;
        s_rr1 = '0; s_rr2 = '0; s_wr = '0; s_wd = '0; s_we = 1'b0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_chain();
        test_reset_midsweep();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
